// File: rtl/conv_window_feeder_pkg.sv
// Shared types for the convolution window feeder.
// Row framing FSM states; pix_ready is low only in GAP.
package conv_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel stream in, window vector out, between the feeder and its neighbours.
// The slave side is the feeder; the master side is upstream source plus the core.
interface conv_window_feeder_if #(
    parameter int IMG_WIDTH = 16,
    parameter int IMG_NB    = 3
);
    logic [IMG_WIDTH-1:0]        pix_data;
    logic                        pix_valid;
    logic                        pix_last;
    logic                        pix_ready;
    logic [IMG_WIDTH*IMG_NB-1:0] img;
    logic                        val;
    logic                        row_done;
    logic                        err;

    modport master (
        output pix_data, pix_valid, pix_last,
        input  pix_ready, img, val, row_done, err
    );

    modport slave (
        input  pix_data, pix_valid, pix_last,
        output pix_ready, img, val, row_done, err
    );
endinterface

// File: rtl/conv_window_feeder_shift.sv
// IMG_NB-deep pixel shift register; lane 0 oldest, top lane newest.
// nxt is the contents after a shift, so the caller can register a window in the same cycle.
module window_shift #(
    parameter int IMG_WIDTH = 16,
    parameter int IMG_NB    = 3
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        shift,
    input  logic [IMG_WIDTH-1:0]        din,
    output logic [IMG_WIDTH*IMG_NB-1:0] win,
    output logic [IMG_WIDTH*IMG_NB-1:0] nxt
);
    assign nxt = {din, win[IMG_WIDTH*IMG_NB-1:IMG_WIDTH]};

    always_ff @(posedge clk) begin
        if (clr) begin
            win <= '0;
        end else if (shift) begin
            win <= nxt;
        end
    end
endmodule

// File: rtl/conv_window_feeder.sv
// Serial-to-window front end for the 1-D convolution core: frames rows,
// emits one registered window per accepted pixel once full, and idles between rows.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH = 16,
    parameter int IMG_NB    = 3,
    parameter int ROW_LEN   = 8,
    parameter int ROW_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_window_feeder_if.slave   bus
);
    localparam int CW = $clog2(ROW_LEN);
    localparam int GW = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
    localparam state_t AFTER_ROW = (ROW_GAP == 0) ? FILL : GAP;

    state_t                      state_q, state_d;
    logic [CW-1:0]               col_q;
    logic [GW-1:0]               gap_q;
    logic                        xfer, at_end, fill_done, term, emit;
    logic [IMG_WIDTH*IMG_NB-1:0] win, nxt;
    logic [IMG_WIDTH*IMG_NB-1:0] img_q;
    logic                        val_q, row_done_q, err_q;

    assign bus.pix_ready = !rst && (state_q != GAP);
    assign xfer          = bus.pix_valid && bus.pix_ready;
    assign at_end        = (col_q == CW'(ROW_LEN - 1));
    assign fill_done     = (col_q == CW'(IMG_NB - 1));
    assign term          = xfer && (bus.pix_last || at_end);
    assign emit          = xfer && ((state_q == RUN) || (state_q == FILL && fill_done));

    // Termination clears the window so no output ever mixes two rows.
    window_shift #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_NB    (IMG_NB)
    ) u_shift (
        .clk   (clk),
        .clr   (rst || term),
        .shift (xfer),
        .din   (bus.pix_data),
        .win   (win),
        .nxt   (nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (term) begin
                    state_d = AFTER_ROW;
                end else if (xfer && fill_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (term) begin
                    state_d = AFTER_ROW;
                end
            end
            GAP: begin
                if (int'(gap_q) >= ROW_GAP - 1) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            gap_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (term) begin
                col_q <= '0;
            end else if (xfer) begin
                col_q <= col_q + 1'b1;
            end
            gap_q <= (state_q == GAP) ? gap_q + 1'b1 : '0;
            // Early last, or a full row without last, are both framing faults.
            if (xfer && (bus.pix_last != at_end)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Output stage: one cycle after the completing transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_q      <= '0;
            val_q      <= 1'b0;
            row_done_q <= 1'b0;
        end else begin
            val_q      <= emit;
            row_done_q <= term;
            if (emit) begin
                img_q <= nxt;
            end
        end
    end

    assign bus.img      = img_q;
    assign bus.val      = val_q;
    assign bus.row_done = row_done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with IMG_NB=3, ROW_LEN=5, ROW_GAP=2.
module tb_conv_window_feeder;
    localparam int IW = 16;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    conv_window_feeder_if #(.IMG_WIDTH(IW), .IMG_NB(NB)) bus ();

    conv_window_feeder #(
        .IMG_WIDTH (IW),
        .IMG_NB    (NB),
        .ROW_LEN   (5),
        .ROW_GAP   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [IW*NB-1:0] w3(input int a, input int b, input int c);
        logic [IW-1:0] la, lb, lc;
        la = IW'(a);
        lb = IW'(b);
        lc = IW'(c);
        return {lc, lb, la};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic last);
        bus.pix_valid = 1'b1;
        bus.pix_data  = IW'(d);
        bus.pix_last  = last;
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic idle();
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_img", 64'(bus.img), 64'd0);
        chk("rst_val", 64'(bus.val), 64'd0);
        chk("rst_row_done", 64'(bus.row_done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_ready_low", 64'(bus.pix_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready_high", 64'(bus.pix_ready), 64'd1);
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.pix_data  = '0;
        @(posedge clk);
        do_reset();

        // Continuous row 1..5
        send(1, 1'b0); chk("t1_val_p1", 64'(bus.val), 64'd0);
        send(2, 1'b0); chk("t1_val_p2", 64'(bus.val), 64'd0);
        send(3, 1'b0); chk("t1_val_w0", 64'(bus.val), 64'd1);
        chk("t1_img_w0", 64'(bus.img), 64'(w3(1, 2, 3)));
        send(4, 1'b0); chk("t1_img_w1", 64'(bus.img), 64'(w3(2, 3, 4)));
        chk("t1_rd_early", 64'(bus.row_done), 64'd0);
        send(5, 1'b1); chk("t1_val_w2", 64'(bus.val), 64'd1);
        chk("t1_img_w2", 64'(bus.img), 64'(w3(3, 4, 5)));
        chk("t1_row_done", 64'(bus.row_done), 64'd1);
        chk("t1_err", 64'(bus.err), 64'd0);
        chk("t1_ready_gap0", 64'(bus.pix_ready), 64'd0);
        idle();
        chk("t1_val_gap", 64'(bus.val), 64'd0);
        chk("t1_rd_gap", 64'(bus.row_done), 64'd0);
        chk("t1_ready_gap1", 64'(bus.pix_ready), 64'd0);
        chk("t1_img_hold", 64'(bus.img), 64'(w3(3, 4, 5)));
        idle();
        chk("t1_ready_back", 64'(bus.pix_ready), 64'd1);

        // Same row with a bubble after every pixel
        send(1, 1'b0); idle();
        send(2, 1'b0); idle();
        chk("t2_val_none", 64'(bus.val), 64'd0);
        send(3, 1'b0); chk("t2_img_w0", 64'(bus.img), 64'(w3(1, 2, 3)));
        chk("t2_val_w0", 64'(bus.val), 64'd1);
        idle();        chk("t2_val_bub0", 64'(bus.val), 64'd0);
        send(4, 1'b0); chk("t2_img_w1", 64'(bus.img), 64'(w3(2, 3, 4)));
        idle();        chk("t2_val_bub1", 64'(bus.val), 64'd0);
        send(5, 1'b1); chk("t2_img_w2", 64'(bus.img), 64'(w3(3, 4, 5)));
        chk("t2_row_done", 64'(bus.row_done), 64'd1);
        idle();        chk("t2_val_bub2", 64'(bus.val), 64'd0);
        idle();

        // Back-to-back rows
        for (int i = 1; i <= 5; i++) send(i, i == 5);
        chk("t3_r1_last", 64'(bus.img), 64'(w3(3, 4, 5)));
        idle(); idle();
        send(10, 1'b0); chk("t3_no_mix0", 64'(bus.val), 64'd0);
        send(11, 1'b0); chk("t3_no_mix1", 64'(bus.val), 64'd0);
        send(12, 1'b0); chk("t3_r2_w0", 64'(bus.img), 64'(w3(10, 11, 12)));
        send(13, 1'b0); chk("t3_r2_w1", 64'(bus.img), 64'(w3(11, 12, 13)));
        send(14, 1'b1); chk("t3_r2_w2", 64'(bus.img), 64'(w3(12, 13, 14)));
        chk("t3_err", 64'(bus.err), 64'd0);
        idle(); idle();

        // Short row: early last in FILL
        send(7, 1'b0); chk("t4_val_p7", 64'(bus.val), 64'd0);
        send(8, 1'b1); chk("t4_val_p8", 64'(bus.val), 64'd0);
        chk("t4_row_done", 64'(bus.row_done), 64'd1);
        chk("t4_err", 64'(bus.err), 64'd1);
        chk("t4_ready_gap", 64'(bus.pix_ready), 64'd0);
        idle(); idle();
        send(1, 1'b0);
        send(2, 1'b0); chk("t4_val_p2", 64'(bus.val), 64'd0);
        send(3, 1'b0); chk("t4_img_w0", 64'(bus.img), 64'(w3(1, 2, 3)));
        send(4, 1'b0); chk("t4_img_w1", 64'(bus.img), 64'(w3(2, 3, 4)));
        send(5, 1'b1); chk("t4_img_w2", 64'(bus.img), 64'(w3(3, 4, 5)));
        chk("t4_err_sticky", 64'(bus.err), 64'd1);
        idle(); idle();

        // Missing last: row ends on the fifth pixel anyway
        do_reset();
        for (int i = 1; i <= 4; i++) send(i, 1'b0);
        chk("t5_img_w1", 64'(bus.img), 64'(w3(2, 3, 4)));
        chk("t5_err_before", 64'(bus.err), 64'd0);
        send(5, 1'b0); chk("t5_img_w2", 64'(bus.img), 64'(w3(3, 4, 5)));
        chk("t5_val_w2", 64'(bus.val), 64'd1);
        chk("t5_row_done", 64'(bus.row_done), 64'd1);
        chk("t5_err", 64'(bus.err), 64'd1);
        chk("t5_ready_gap", 64'(bus.pix_ready), 64'd0);
        idle(); idle();

        // Reset in mid-row discards the partial window
        send(1, 1'b0);
        send(2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_img_clr", 64'(bus.img), 64'd0);
        chk("t6_val_clr", 64'(bus.val), 64'd0);
        rst = 1'b0;
        send(20, 1'b0); chk("t6_val_p20", 64'(bus.val), 64'd0);
        send(21, 1'b0); chk("t6_val_p21", 64'(bus.val), 64'd0);
        send(22, 1'b0); chk("t6_img_w0", 64'(bus.img), 64'(w3(20, 21, 22)));
        send(23, 1'b0); chk("t6_img_w1", 64'(bus.img), 64'(w3(21, 22, 23)));
        send(24, 1'b1); chk("t6_img_w2", 64'(bus.img), 64'(w3(22, 23, 24)));
        chk("t6_row_done", 64'(bus.row_done), 64'd1);
        chk("t6_err", 64'(bus.err), 64'd0);
        idle(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
